// File: rtl/dmi_apb_master.sv
// DMI-to-APB3 bridge: turns each DMI request strobe into one APB read or write
// and reports read data plus a sticky 2-bit op status back to the DTM.
module dmi_apb_master #(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              Capture_clk,
    input  logic              TRST,
    input  logic              dmi_hard_reset,
    input  logic              dmi_reset,
    input  logic              dmi_transfer,
    input  logic [AWIDTH-1:0] dmi_address_in,
    input  logic [DWIDTH-1:0] dmi_wdata_in,
    input  logic [1:0]        dmi_op_in,
    output logic [DWIDTH-1:0] dmi_rdata,
    output logic [1:0]        dmi_status,
    output logic              dmi_busy,
    output logic              dmi_done,
    output logic [AWIDTH-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic              r_transQ;
    logic              r_done;
    logic              r_write;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic [DWIDTH-1:0] r_rdata;
    logic [1:0]        r_status;
    logic [CW-1:0]     r_cnt;
    logic              w_req;
    logic              w_accept;
    logic              w_complete;
    logic              w_timeout;

    assign w_req = dmi_transfer & ~r_transQ;

    always_ff @(posedge Capture_clk or negedge TRST) begin
        if (!TRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req && (dmi_op_in == 2'd1 || dmi_op_in == 2'd2) && r_status == 2'b00) begin
                    w_accept    = 1'b1;
                    w_stateNext = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_stateNext = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    w_complete  = 1'b1;
                    w_stateNext = ST_IDLE;
                end else if (r_cnt == TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
        if (dmi_hard_reset) begin
            w_stateNext = ST_IDLE;
        end
    end

    // Request registers only load in IDLE so the APB fields stay frozen while a
    // transfer is in flight; later status writes override earlier ones.
    always_ff @(posedge Capture_clk or negedge TRST) begin
        if (!TRST) begin
            r_transQ <= 1'b0;
            r_done   <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_status <= 2'b00;
            r_cnt    <= '0;
        end else if (dmi_hard_reset) begin
            r_transQ <= 1'b0;
            r_done   <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_status <= 2'b00;
            r_cnt    <= '0;
        end else begin
            r_transQ <= dmi_transfer;
            r_done   <= 1'b0;
            if (r_state == ST_IDLE && w_req) begin
                r_addr  <= {dmi_address_in[AWIDTH-3:0], 2'b00};
                r_wdata <= dmi_wdata_in;
                r_write <= (dmi_op_in == 2'd2);
                if (!w_accept) begin
                    r_done <= 1'b1;
                end
                if (dmi_op_in == 2'd3 && r_status == 2'b00) begin
                    r_status <= 2'b10;
                end
            end
            if (w_complete || w_timeout) begin
                r_done <= 1'b1;
            end
            if (w_complete && !PSLVERR && !r_write) begin
                r_rdata <= PRDATA;
            end
            if ((w_timeout || (w_complete && PSLVERR)) && r_status == 2'b00) begin
                r_status <= 2'b10;
            end
            if (r_state != ST_IDLE && w_req) begin
                r_status <= 2'b11;
            end
            if (dmi_reset) begin
                r_status <= 2'b00;
            end
            if (r_state == ST_SETUP) begin
                r_cnt <= '0;
            end else if (r_state == ST_ACCESS && !PREADY && r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign dmi_rdata  = r_rdata;
    assign dmi_status = r_status;
    assign dmi_done   = r_done;
    assign dmi_busy   = (r_state != ST_IDLE);
    assign PSEL       = (r_state != ST_IDLE);
    assign PENABLE    = (r_state == ST_ACCESS);
    assign PADDR      = (r_state != ST_IDLE) ? r_addr : '0;
    assign PWDATA     = (r_state != ST_IDLE) ? r_wdata : '0;
    assign PWRITE     = (r_state != ST_IDLE) ? r_write : 1'b0;

endmodule

// File: tb/tb_dmi_apb_master.sv
// Directed bench for dmi_apb_master: one task per scenario, each with its own
// hand-computed expectations, built with TIMEOUT=4 so the abort path is short.
module tb_dmi_apb_master;

    logic        Capture_clk;
    logic        TRST;
    logic        dmi_hard_reset;
    logic        dmi_reset;
    logic        dmi_transfer;
    logic [31:0] dmi_address_in;
    logic [31:0] dmi_wdata_in;
    logic [1:0]  dmi_op_in;
    logic [31:0] dmi_rdata;
    logic [1:0]  dmi_status;
    logic        dmi_busy;
    logic        dmi_done;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int checks = 0;
    int errors = 0;

    dmi_apb_master #(.DWIDTH(32), .AWIDTH(32), .TIMEOUT(4)) dut (
        .Capture_clk(Capture_clk), .TRST(TRST),
        .dmi_hard_reset(dmi_hard_reset), .dmi_reset(dmi_reset),
        .dmi_transfer(dmi_transfer), .dmi_address_in(dmi_address_in),
        .dmi_wdata_in(dmi_wdata_in), .dmi_op_in(dmi_op_in),
        .dmi_rdata(dmi_rdata), .dmi_status(dmi_status),
        .dmi_busy(dmi_busy), .dmi_done(dmi_done),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial Capture_clk = 1'b0;
    always #5 Capture_clk = ~Capture_clk;

    // Raises the strobe on a negedge; returns at the N+1 sampling point.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] op);
        @(negedge Capture_clk);
        dmi_address_in = addr;
        dmi_wdata_in   = data;
        dmi_op_in      = op;
        dmi_transfer   = 1'b1;
        @(negedge Capture_clk);
    endtask

    task automatic pulse_dmi_reset();
        @(negedge Capture_clk);
        dmi_reset = 1'b1;
        @(negedge Capture_clk);
        dmi_reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Capture_clk);
        checks++;
        if ({dmi_rdata, dmi_status, dmi_busy, dmi_done} !== 36'h0) begin
            errors++;
            $display("[TB] FAIL reset_dmi: got rdata=%h status=%b busy=%b done=%b required all 0", dmi_rdata, dmi_status, dmi_busy, dmi_done);
        end
        checks++;
        if ({PADDR, PSEL, PENABLE, PWRITE, PWDATA} !== 67'h0) begin
            errors++;
            $display("[TB] FAIL reset_apb: got paddr=%h psel=%b pen=%b pwrite=%b pwdata=%h required all 0", PADDR, PSEL, PENABLE, PWRITE, PWDATA);
        end
        TRST = 1'b1;
    endtask

    task automatic test_read_ok();
        PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hDEADBEEF;
        applyStimulus(32'h11, 32'h0, 2'd1);
        dmi_transfer = 1'b0;
        checks++;
        if ({PSEL, PENABLE, dmi_busy, dmi_done} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL read_setup: got psel/pen/busy/done=%b%b%b%b required 1010", PSEL, PENABLE, dmi_busy, dmi_done);
        end
        checks++;
        if (PADDR !== 32'h44 || PWRITE !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_addr: got paddr=%h pwrite=%b required 44 0", PADDR, PWRITE);
        end
        @(negedge Capture_clk);
        checks++;
        if ({PSEL, PENABLE, dmi_done} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL read_access: got psel/pen/done=%b%b%b required 110", PSEL, PENABLE, dmi_done);
        end
        @(negedge Capture_clk);
        checks++;
        if ({PSEL, PENABLE, dmi_busy, dmi_done} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL read_done: got psel/pen/busy/done=%b%b%b%b required 0001", PSEL, PENABLE, dmi_busy, dmi_done);
        end
        checks++;
        if (dmi_rdata !== 32'hDEADBEEF || dmi_status !== 2'b00) begin
            errors++;
            $display("[TB] FAIL read_data: got rdata=%h status=%b required deadbeef 00", dmi_rdata, dmi_status);
        end
        @(negedge Capture_clk);
        checks++;
        if (dmi_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_done_pulse: got done=%b required 0", dmi_done);
        end
    endtask

    task automatic test_write_wait();
        PREADY = 1'b0;
        applyStimulus(32'h10, 32'h1, 2'd2);
        dmi_transfer = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            @(negedge Capture_clk);
            checks++;
            if ({PSEL, PENABLE, PWRITE, dmi_done} !== 4'b1110 || PWDATA !== 32'h1 || PADDR !== 32'h40) begin
                errors++;
                $display("[TB] FAIL write_hold_%0d: got psel/pen/pwrite/done=%b%b%b%b pwdata=%h paddr=%h required 1110 1 40", k, PSEL, PENABLE, PWRITE, dmi_done, PWDATA, PADDR);
            end
            if (k == 5) PREADY = 1'b1;
        end
        @(negedge Capture_clk);
        checks++;
        if ({PSEL, dmi_done, dmi_status} !== 4'b0100 || dmi_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL write_done: got psel=%b done=%b status=%b rdata=%h required 0 1 00 deadbeef", PSEL, dmi_done, dmi_status, dmi_rdata);
        end
    endtask

    task automatic test_slverr_sticky();
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h12345678;
        applyStimulus(32'h20, 32'h0, 2'd1);
        dmi_transfer = 1'b0;
        repeat (2) @(negedge Capture_clk);
        checks++;
        if (dmi_done !== 1'b1 || dmi_status !== 2'b10 || dmi_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL slverr: got done=%b status=%b rdata=%h required 1 10 deadbeef", dmi_done, dmi_status, dmi_rdata);
        end
        PSLVERR = 1'b0;
        applyStimulus(32'h21, 32'h0, 2'd1);
        dmi_transfer = 1'b0;
        checks++;
        if ({PSEL, dmi_done, dmi_status} !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL sticky_skip: got psel=%b done=%b status=%b required 0 1 10", PSEL, dmi_done, dmi_status);
        end
        @(negedge Capture_clk);
        checks++;
        if ({PSEL, dmi_done} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL sticky_idle: got psel=%b done=%b required 0 0", PSEL, dmi_done);
        end
        pulse_dmi_reset();
        checks++;
        if (dmi_status !== 2'b00) begin
            errors++;
            $display("[TB] FAIL dmi_reset_clear: got status=%b required 00", dmi_status);
        end
        PRDATA = 32'hCAFEF00D;
        applyStimulus(32'h5, 32'h0, 2'd1);
        dmi_transfer = 1'b0;
        repeat (2) @(negedge Capture_clk);
        checks++;
        if (dmi_done !== 1'b1 || dmi_status !== 2'b00 || dmi_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("[TB] FAIL read_after_clear: got done=%b status=%b rdata=%h required 1 00 cafef00d", dmi_done, dmi_status, dmi_rdata);
        end
    endtask

    task automatic test_nop_op3();
        applyStimulus(32'h30, 32'h0, 2'd0);
        dmi_transfer = 1'b0;
        checks++;
        if ({PSEL, dmi_done, dmi_status} !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL nop: got psel=%b done=%b status=%b required 0 1 00", PSEL, dmi_done, dmi_status);
        end
        applyStimulus(32'h31, 32'h0, 2'd3);
        dmi_transfer = 1'b0;
        checks++;
        if ({PSEL, dmi_done, dmi_status} !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL op3: got psel=%b done=%b status=%b required 0 1 10", PSEL, dmi_done, dmi_status);
        end
        pulse_dmi_reset();
    endtask

    task automatic test_timeout();
        int penCount = 0;
        int doneAt = 0;
        PREADY = 1'b0;
        applyStimulus(32'h3, 32'h0, 2'd1);
        dmi_transfer = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (PENABLE === 1'b1) penCount++;
            if (dmi_done === 1'b1 && doneAt == 0) doneAt = k;
            @(negedge Capture_clk);
        end
        checks++;
        if (penCount != 4) begin
            errors++;
            $display("[TB] FAIL timeout_penable: got %0d cycles required 4", penCount);
        end
        checks++;
        if (doneAt != 6) begin
            errors++;
            $display("[TB] FAIL timeout_done: got done at edge+%0d required edge+6", doneAt);
        end
        checks++;
        if (dmi_status !== 2'b10 || dmi_rdata !== 32'hCAFEF00D || PSEL !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_status: got status=%b rdata=%h psel=%b required 10 cafef00d 0", dmi_status, dmi_rdata, PSEL);
        end
        pulse_dmi_reset();
    endtask

    task automatic test_back_to_back();
        int doneCount = 0;
        PREADY = 1'b0;
        applyStimulus(32'h8, 32'hA5, 2'd2);
        dmi_transfer = 1'b0;
        @(negedge Capture_clk);
        dmi_address_in = 32'h99;
        dmi_op_in = 2'd1;
        dmi_transfer = 1'b1;
        @(negedge Capture_clk);
        checks++;
        if (dmi_status !== 2'b11 || PADDR !== 32'h20 || PENABLE !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_drop: got status=%b paddr=%h pen=%b required 11 20 1", dmi_status, PADDR, PENABLE);
        end
        dmi_transfer = 1'b0;
        PREADY = 1'b1;
        @(negedge Capture_clk);
        checks++;
        if ({PSEL, dmi_done, dmi_status} !== 4'b0111) begin
            errors++;
            $display("[TB] FAIL busy_complete: got psel=%b done=%b status=%b required 0 1 11", PSEL, dmi_done, dmi_status);
        end
        @(negedge Capture_clk);
        checks++;
        if ({PSEL, dmi_done} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL busy_no_second: got psel=%b done=%b required 0 0", PSEL, dmi_done);
        end
        applyStimulus(32'h1, 32'h0, 2'd1);
        for (int k = 1; k <= 6; k++) begin
            if (dmi_done === 1'b1) doneCount++;
            @(negedge Capture_clk);
        end
        dmi_transfer = 1'b0;
        checks++;
        if (doneCount != 1) begin
            errors++;
            $display("[TB] FAIL held_transfer: got %0d done pulses required 1", doneCount);
        end
        pulse_dmi_reset();
    endtask

    task automatic test_trst_async();
        PREADY = 1'b0;
        applyStimulus(32'h9, 32'h77, 2'd2);
        dmi_transfer = 1'b0;
        @(negedge Capture_clk);
        #1 TRST = 1'b0;
        #1;
        checks++;
        if ({PSEL, PENABLE, PWRITE, dmi_busy, dmi_done} !== 5'b0 || PADDR !== 32'h0 || PWDATA !== 32'h0 || dmi_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL trst_async: got psel=%b pen=%b pwrite=%b busy=%b paddr=%h pwdata=%h rdata=%h required all 0", PSEL, PENABLE, PWRITE, dmi_busy, PADDR, PWDATA, dmi_rdata);
        end
        @(negedge Capture_clk);
        TRST = 1'b1;
    endtask

    task automatic test_hard_reset();
        PREADY = 1'b1; PRDATA = 32'h600DF00D;
        applyStimulus(32'h6, 32'h0, 2'd1);
        dmi_transfer = 1'b0;
        repeat (2) @(negedge Capture_clk);
        checks++;
        if (dmi_rdata !== 32'h600DF00D) begin
            errors++;
            $display("[TB] FAIL hard_pre_read: got rdata=%h required 600df00d", dmi_rdata);
        end
        PREADY = 1'b0;
        applyStimulus(32'h7, 32'h0, 2'd1);
        dmi_transfer = 1'b0;
        @(negedge Capture_clk);
        dmi_hard_reset = 1'b1;
        @(negedge Capture_clk);
        dmi_hard_reset = 1'b0;
        checks++;
        if ({PSEL, PENABLE, dmi_busy, dmi_done, dmi_status} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL hard_reset_ctrl: got psel=%b pen=%b busy=%b done=%b status=%b required all 0", PSEL, PENABLE, dmi_busy, dmi_done, dmi_status);
        end
        checks++;
        if (dmi_rdata !== 32'h0 || PADDR !== 32'h0) begin
            errors++;
            $display("[TB] FAIL hard_reset_data: got rdata=%h paddr=%h required 0 0", dmi_rdata, PADDR);
        end
        @(negedge Capture_clk);
        checks++;
        if ({PSEL, dmi_done} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL hard_reset_after: got psel=%b done=%b required 0 0", PSEL, dmi_done);
        end
    endtask

    initial begin
        TRST = 1'b0;
        dmi_hard_reset = 1'b0;
        dmi_reset = 1'b0;
        dmi_transfer = 1'b0;
        dmi_address_in = '0;
        dmi_wdata_in = '0;
        dmi_op_in = 2'd0;
        PRDATA = '0;
        PREADY = 1'b0;
        PSLVERR = 1'b0;
        test_reset();
        test_read_ok();
        test_write_wait();
        test_slverr_sticky();
        test_nop_op3();
        test_timeout();
        test_back_to_back();
        test_trst_async();
        test_hard_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
